dht_rx: RTL and testbench
=========================

// Module: dht_rx
// PURPOSE
//  Receive side of the DHT11 single-wire link. The start controller pulls the line low for 18 ms,
//  then pulses `start`. This block then times the sensor's 80/80 us response and decodes the
//  40-bit frame, MSB first: hum_int, hum_dec, tmp_int, tmp_dec, checksum. It verifies the
//  checksum and presents the four data bytes to the display/readout logic with a valid pulse.
// PARAMETERS
//  CLK_PER_US     100  clk cycles per microsecond (100 MHz system clock)
//  BIT_THRESH_US  40   high-phase width > this => bit 1, <= this => bit 0
//  TIMEOUT_US     200  max width of any single line phase before abort
// PORTS
//  clk           in   1  system clock, all logic on posedge
//  rst           in   1  asynchronous, active-low reset
//  start         in   1  1-cycle pulse: host released line, begin capture
//  dht_in        in   1  raw DHT data line (asynchronous to clk)
//  busy          out  1  high from accepted start until frame end/abort
//  valid         out  1  1-cycle pulse: new good frame on data outputs
//  hum_int       out  8  humidity integer byte
//  hum_dec       out  8  humidity decimal byte
//  tmp_int       out  8  temperature integer byte
//  tmp_dec       out  8  temperature decimal byte
//  chk_err       out  1  1-cycle pulse: checksum mismatch, data outputs not updated
//  timeout_err   out  1  1-cycle pulse: phase exceeded TIMEOUT_US, capture aborted
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; busy, valid, chk_err, timeout_err = 0; all data bytes = 8'h00.
//  - dht_in passes a 2-FF synchronizer. Edges are detected on the synchronized line.
//  - us_tick prescaler counts 0..CLK_PER_US-1 and clears on every sync edge and state change.
//  - width counter (8 b, saturates at 255) increments per us_tick and clears with the prescaler.
//  - FSM: IDLE -start-> WAIT_LOW -fall-> RESP_LOW -rise-> RESP_HIGH -fall-> BIT_LOW
//    -rise-> BIT_HIGH.
//    On fall in BIT_HIGH: shift in (width>BIT_THRESH_US), bit_cnt++. If bit_cnt reaches 40 -> CHECK,
//    else -> BIT_LOW. CHECK (1 cycle) -> IDLE.
//  - Response widths are not range-checked; only TIMEOUT_US applies. Width > TIMEOUT_US in any
//    non-IDLE state => timeout_err pulse, -> IDLE.
//  - CHECK: sum of bytes 0..3 mod 256 == byte 4 => load outputs, valid pulse next cycle.
//    Mismatch => chk_err pulse next cycle, outputs hold previous frame.
//  - busy = (state != IDLE). start while busy is ignored. start in IDLE with the line already low
//    proceeds; a fall is required to leave WAIT_LOW.
//  - Latency: valid/chk_err rise 2 clk after the sync falling edge that ends bit 39 (CHECK, then
//    pulse). Add the 2-cycle synchronizer delay measured from dht_in.
//  - Async reset mid-frame discards the shift register and bit_cnt; no pulse outputs fire.
// CONFIGURATION
//  DHT_RX_GLITCH_FILTER_EN defined: a 3-sample majority filter follows the synchronizer, adding
//  2 clk latency to all edges and rejecting single-cycle spikes.
//  DHT_RX_GLITCH_FILTER_EN undefined: synchronizer output is used directly; any 1-cycle spike is
//  an edge.
// STRUCTURE
//  dht_pkg: typedef enum dht_rx_state_t {IDLE, WAIT_LOW, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH,
//  CHECK}; localparam DHT_FRAME_BITS=40; default timing constants (us).
//  Sub-module dht_line_sync: synchronizer + optional filter + rise/fall pulse outputs.
//  Prescaler, width counter, FSM, shift register and checksum stay in dht_rx.
// TESTING  (CLK_PER_US=4 for sim speed; sensor BFM drives dht_in)
//  1 Good frame 37 00 18 05 54 -> one valid pulse; hum_int=8'h37 hum_dec=0 tmp_int=8'h18
//    tmp_dec=5; no err.
//  2 Frame 37 00 18 05 55 -> chk_err pulse, no valid; outputs keep frame-1 values.
//  3 start, dht_in held high -> timeout_err pulse when width > 200 us; busy falls the same cycle.
//  4 Bit widths 28/40/41/70 us high -> decoded bits 0/0/1/1.
//  5 Second start pulse mid-frame -> ignored, frame decodes normally.
//  6 rst=0 at bit 20, then restart -> outputs 0 after reset, no pulses; next full frame decodes.
//  7 With DHT_RX_GLITCH_FILTER_EN: 1-cycle low spike inside an 70 us high -> still bit 1, frame valid.

Source files
------------

// File: rtl/dht_pkg.sv
// Shared types and default timing for the DHT11 receive path.
package dht_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOW,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        CHECK
    } dht_rx_state_t;

    localparam int DHT_FRAME_BITS    = 40;
    localparam int DHT_CLK_PER_US    = 100;
    localparam int DHT_BIT_THRESH_US = 40;
    localparam int DHT_TIMEOUT_US    = 200;

    // Frame is hum_int, hum_dec, tmp_int, tmp_dec, checksum (MSB first).
    function automatic logic dht_chk_ok(input logic [39:0] frame);
        logic [7:0] sum;
        sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
        return sum == frame[7:0];
    endfunction

endpackage

// File: rtl/dht_rx_if.sv
// Handshake and data bundle between the DHT line, the start controller and the readout logic.
interface dht_rx_if;
    logic       start;
    logic       dht_in;
    logic       busy;
    logic       valid;
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] tmp_int;
    logic [7:0] tmp_dec;
    logic       chk_err;
    logic       timeout_err;

    modport master (
        output start, dht_in,
        input  busy, valid, hum_int, hum_dec, tmp_int, tmp_dec, chk_err, timeout_err
    );

    modport slave (
        input  start, dht_in,
        output busy, valid, hum_int, hum_dec, tmp_int, tmp_dec, chk_err, timeout_err
    );
endinterface

// File: rtl/dht_line_sync.sv
// 2-FF synchronizer for the DHT line with rise/fall pulses.
// DHT_RX_GLITCH_FILTER_EN adds a registered 3-sample majority filter (2 clk extra latency).
module dht_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic s1, s2, line, line_q;

    // Idle line is pulled high, so reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

`ifdef DHT_RX_GLITCH_FILTER_EN
    logic h1, h2, filt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h1   <= 1'b1;
            h2   <= 1'b1;
            filt <= 1'b1;
        end else begin
            h1   <= s2;
            h2   <= h1;
            filt <= (s2 & h1) | (s2 & h2) | (h1 & h2);
        end
    end

    assign line = filt;
`else
    assign line = s2;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) line_q <= 1'b1;
        else      line_q <= line;
    end

    assign rise = line & ~line_q;
    assign fall = ~line & line_q;
endmodule

// File: rtl/dht_rx.sv
// DHT11 receiver: times the sensor response, decodes the 40-bit frame and verifies the checksum.
// Line conditioning (optionally glitch-filtered via DHT_RX_GLITCH_FILTER_EN) lives in dht_line_sync.
module dht_rx
    import dht_pkg::*;
#(
    parameter int CLK_PER_US    = DHT_CLK_PER_US,
    parameter int BIT_THRESH_US = DHT_BIT_THRESH_US,
    parameter int TIMEOUT_US    = DHT_TIMEOUT_US
) (
    input logic     clk,
    input logic     rst,
    dht_rx_if.slave dht
);
    localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

    dht_rx_state_t state;
    logic [PW-1:0] presc;
    logic [7:0]    width;
    logic [5:0]    bit_cnt;
    logic [39:0]   shreg;
    logic [7:0]    hum_int, hum_dec, tmp_int, tmp_dec;
    logic          valid, chk_err, timeout_err;
    logic          rise, fall, us_tick;

    dht_line_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (dht.dht_in),
        .rise (rise),
        .fall (fall)
    );

    assign us_tick = (presc == PW'(CLK_PER_US - 1));

    // The cycle that sees an edge is the first cycle of the new phase, hence presc restarts at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            presc       <= '0;
            width       <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            hum_int     <= '0;
            hum_dec     <= '0;
            tmp_int     <= '0;
            tmp_dec     <= '0;
            valid       <= 1'b0;
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            valid       <= 1'b0;
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;

            if (rise || fall) begin
                presc <= PW'(1);
                width <= '0;
            end else if (us_tick) begin
                presc <= '0;
                if (width != 8'hFF) width <= width + 8'd1;
            end else begin
                presc <= presc + PW'(1);
            end

            if (state != IDLE && width > 8'(TIMEOUT_US)) begin
                state       <= IDLE;
                timeout_err <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (dht.start) begin
                        state   <= WAIT_LOW;
                        bit_cnt <= '0;
                        presc   <= PW'(1);
                        width   <= '0;
                    end
                    WAIT_LOW:  if (fall) state <= RESP_LOW;
                    RESP_LOW:  if (rise) state <= RESP_HIGH;
                    RESP_HIGH: if (fall) state <= BIT_LOW;
                    BIT_LOW:   if (rise) state <= BIT_HIGH;
                    BIT_HIGH: if (fall) begin
                        shreg   <= {shreg[38:0], (width > 8'(BIT_THRESH_US))};
                        bit_cnt <= bit_cnt + 6'd1;
                        state   <= (bit_cnt == 6'(DHT_FRAME_BITS - 1)) ? CHECK : BIT_LOW;
                    end
                    CHECK: begin
                        if (dht_chk_ok(shreg)) begin
                            {hum_int, hum_dec, tmp_int, tmp_dec} <= shreg[39:8];
                            valid <= 1'b1;
                        end else begin
                            chk_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign dht.busy        = (state != IDLE);
    assign dht.valid       = valid;
    assign dht.chk_err     = chk_err;
    assign dht.timeout_err = timeout_err;
    assign dht.hum_int     = hum_int;
    assign dht.hum_dec     = hum_dec;
    assign dht.tmp_int     = tmp_int;
    assign dht.tmp_dec     = tmp_dec;
endmodule

// File: tb/tb_dht_rx.sv
// Self-checking bench for dht_rx: sensor BFM with randomized bit widths and a frame-level model.
module tb_dht_rx;
    import dht_pkg::*;

    localparam int CPU = 4;
`ifdef DHT_RX_GLITCH_FILTER_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 4;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dht_rx_if dif ();

    dht_rx #(.CLK_PER_US(CPU)) dut (
        .clk (clk),
        .rst (rst),
        .dht (dif)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_valid = 0, n_chk = 0, n_to = 0, pulse_cyc = 0;
    int fall_cyc = 0;
    int hw [40];
    int start_at_bit = -1;
    int abort_at_bit = -1;
    int spike_bit    = -1;
    logic [31:0] exp_data = 32'h0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (dif.valid)       begin n_valid++; pulse_cyc = cyc; end
        if (dif.chk_err)     begin n_chk++;   pulse_cyc = cyc; end
        if (dif.timeout_err) n_to++;
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: frame bits come from the high widths by the >40 us rule.
    function automatic logic [39:0] model_decode();
        logic [39:0] d;
        for (int i = 0; i < 40; i++) d[39-i] = (hw[i] > 40);
        return d;
    endfunction

    function automatic logic model_good(input logic [39:0] d);
        int s;
        s = d[39:32] + d[31:24] + d[23:16] + d[15:8];
        return (s % 256) == int'(d[7:0]);
    endfunction

    function automatic logic [39:0] mk_frame(input logic [31:0] data, input bit corrupt);
        int s;
        logic [7:0] c;
        s = (data[31:24] + data[23:16] + data[15:8] + data[7:0]) % 256;
        if (corrupt) s = (s + int'($urandom_range(255, 1))) % 256;
        c = s[7:0];
        return {data, c};
    endfunction

    task automatic set_widths(input logic [39:0] f);
        for (int i = 0; i < 40; i++)
            hw[i] = f[39-i] ? int'($urandom_range(60, 41)) : int'($urandom_range(40, 20));
    endtask

    // Sensor BFM; bit low phases are shortened to keep the run short.
    task automatic drive_frame();
        @(negedge clk) dif.start = 1'b1;
        @(negedge clk) dif.start = 1'b0;
        hold(20*CPU - 1);
        dif.dht_in = 1'b0; hold(80*CPU);
        dif.dht_in = 1'b1; hold(80*CPU);
        for (int i = 0; i < 40; i++) begin
            dif.dht_in = 1'b0;
            if (i == abort_at_bit) begin
                hold(4*CPU);
                return;
            end
            if (i == start_at_bit) begin
                dif.start = 1'b1; hold(1); dif.start = 1'b0; hold(8*CPU - 1);
            end else begin
                hold(8*CPU);
            end
            dif.dht_in = 1'b1;
            if (i == spike_bit) begin
                hold(30*CPU); dif.dht_in = 1'b0; hold(1); dif.dht_in = 1'b1;
                hold(hw[i]*CPU - 30*CPU - 1);
            end else begin
                hold(hw[i]*CPU);
            end
        end
        dif.dht_in = 1'b0;
        fall_cyc = cyc;
        hold(20*CPU);
        dif.dht_in = 1'b1;
        hold(5*CPU);
    endtask

    task automatic test_reset();
        rst = 1'b0; dif.start = 1'b0; dif.dht_in = 1'b1;
        hold(3);
        total++; if (dif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", dif.busy); end
        total++; if (dif.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", dif.valid); end
        total++; if (dif.chk_err !== 1'b0) begin bad++; $display("FAIL reset_chk_err got=%b exp=0", dif.chk_err); end
        total++; if (dif.timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", dif.timeout_err); end
        total++; if ({dif.hum_int, dif.hum_dec, dif.tmp_int, dif.tmp_dec} !== 32'h0) begin
            bad++; $display("FAIL reset_data got=%h exp=00000000", {dif.hum_int, dif.hum_dec, dif.tmp_int, dif.tmp_dec});
        end
        rst = 1'b1;
        hold(4);
    endtask

    // Runs one frame and checks pulse counts, data and latency against the model.
    task automatic test_frame(input string name, input logic [39:0] f);
        logic [39:0] d;
        int v0, c0, t0, ev;
        set_widths(f);
        if (spike_bit >= 0) hw[spike_bit] = 70;
        if (name == "bit_widths") begin hw[0] = 28; hw[1] = 40; hw[2] = 41; hw[3] = 70; end
        v0 = n_valid; c0 = n_chk; t0 = n_to;
        drive_frame();
        d  = model_decode();
        ev = model_good(d) ? 1 : 0;
        if (ev == 1) exp_data = d[39:8];
        total++; if (n_valid - v0 !== ev) begin bad++; $display("FAIL %s valid_cnt got=%0d exp=%0d", name, n_valid - v0, ev); end
        total++; if (n_chk - c0 !== 1 - ev) begin bad++; $display("FAIL %s chk_cnt got=%0d exp=%0d", name, n_chk - c0, 1 - ev); end
        total++; if (n_to - t0 !== 0) begin bad++; $display("FAIL %s timeout_cnt got=%0d exp=0", name, n_to - t0); end
        total++; if ({dif.hum_int, dif.hum_dec, dif.tmp_int, dif.tmp_dec} !== exp_data) begin
            bad++; $display("FAIL %s data got=%h exp=%h", name, {dif.hum_int, dif.hum_dec, dif.tmp_int, dif.tmp_dec}, exp_data);
        end
        total++; if (pulse_cyc - fall_cyc !== LAT) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", name, pulse_cyc - fall_cyc, LAT); end
        total++; if (dif.busy !== 1'b0) begin bad++; $display("FAIL %s busy_after got=%b exp=0", name, dif.busy); end
    endtask

    task automatic test_good_frame();
        test_frame("good", 40'h37_00_18_05_54);
        total++; if ({dif.hum_int, dif.hum_dec, dif.tmp_int, dif.tmp_dec} !== 32'h37001805) begin
            bad++; $display("FAIL good_bytes got=%h exp=37001805", {dif.hum_int, dif.hum_dec, dif.tmp_int, dif.tmp_dec});
        end
    endtask

    task automatic test_bad_checksum();
        test_frame("bad_chk", 40'h37_00_18_05_55);
        total++; if ({dif.hum_int, dif.hum_dec, dif.tmp_int, dif.tmp_dec} !== 32'h37001805) begin
            bad++; $display("FAIL bad_chk_hold got=%h exp=37001805", {dif.hum_int, dif.hum_dec, dif.tmp_int, dif.tmp_dec});
        end
    endtask

    task automatic test_timeout();
        int tstart, tto, v0;
        bit found;
        logic busy_at;
        found = 0; tto = 0; busy_at = 1'b1; v0 = n_valid;
        dif.dht_in = 1'b1;
        @(negedge clk) begin dif.start = 1'b1; tstart = cyc; end
        @(negedge clk) dif.start = 1'b0;
        total++; if (dif.busy !== 1'b1) begin bad++; $display("FAIL timeout_busy_start got=%b exp=1", dif.busy); end
        for (int k = 0; k < 300*CPU && !found; k++) begin
            @(negedge clk);
            if (dif.timeout_err) begin found = 1; tto = cyc; busy_at = dif.busy; end
        end
        total++; if (!found) begin bad++; $display("FAIL timeout_pulse got=none exp=pulse"); end
        total++; if (busy_at !== 1'b0) begin bad++; $display("FAIL timeout_busy got=%b exp=0", busy_at); end
        total++; if (found && (tto - tstart < 200*CPU || tto - tstart > 203*CPU)) begin
            bad++; $display("FAIL timeout_when got=%0d exp=%0d..%0d", tto - tstart, 200*CPU, 203*CPU);
        end
        total++; if (n_valid !== v0) begin bad++; $display("FAIL timeout_valid got=%0d exp=%0d", n_valid - v0, 0); end
        hold(10);
    endtask

    task automatic test_bit_widths();
        logic [31:0] data;
        data = $urandom;
        data[31:28] = 4'h3;
        test_frame("bit_widths", mk_frame(data, 1'b0));
        total++; if (dif.hum_int[7:4] !== 4'b0011) begin bad++; $display("FAIL bit_widths_nibble got=%b exp=0011", dif.hum_int[7:4]); end
    endtask

    task automatic test_mid_start();
        start_at_bit = 15;
        test_frame("mid_start", mk_frame($urandom, 1'b0));
        start_at_bit = -1;
    endtask

    task automatic test_reset_mid();
        int v0, c0, t0;
        v0 = n_valid; c0 = n_chk; t0 = n_to;
        abort_at_bit = 20;
        drive_frame();
        abort_at_bit = -1;
        rst = 1'b0;
        hold(2);
        exp_data = 32'h0;
        total++; if ({dif.hum_int, dif.hum_dec, dif.tmp_int, dif.tmp_dec} !== 32'h0) begin
            bad++; $display("FAIL rst_mid_data got=%h exp=00000000", {dif.hum_int, dif.hum_dec, dif.tmp_int, dif.tmp_dec});
        end
        total++; if (dif.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", dif.busy); end
        dif.dht_in = 1'b1;
        hold(2);
        rst = 1'b1;
        hold(10*CPU);
        total++; if (n_valid + n_chk + n_to !== v0 + c0 + t0) begin
            bad++; $display("FAIL rst_mid_pulses got=%0d exp=0", n_valid + n_chk + n_to - v0 - c0 - t0);
        end
        test_frame("after_rst", mk_frame($urandom, 1'b0));
    endtask

    task automatic test_random();
        for (int k = 0; k < 2; k++)
            test_frame("random", mk_frame($urandom, ($urandom_range(2, 0) == 0)));
    endtask

`ifdef DHT_RX_GLITCH_FILTER_EN
    task automatic test_glitch();
        logic [31:0] data;
        data = $urandom;
        data[31] = 1'b1;
        spike_bit = 0;
        test_frame("glitch", mk_frame(data, 1'b0));
        spike_bit = -1;
        total++; if (dif.hum_int[7] !== 1'b1) begin bad++; $display("FAIL glitch_bit got=%b exp=1", dif.hum_int[7]); end
    endtask
`endif

    initial begin
        dif.start  = 1'b0;
        dif.dht_in = 1'b1;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_timeout();
        test_bit_widths();
        test_mid_start();
        test_reset_mid();
        test_random();
`ifdef DHT_RX_GLITCH_FILTER_EN
        test_glitch();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
